// File: rtl/mult_ctrl_pkg.sv
// Shared types for the sequential shift-add multiplier control path.
package mult_ctrl_pkg;

    localparam int N_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control sequencer for the 8x8 signed shift-add multiplier: turns one Run request
// into CLR followed by N_BITS add/shift pairs, the last add being a subtract.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic clr_ax,
    output logic ld_b,
    output logic ld_ax,
    output logic sub_sel,
    output logic shift,
    output logic busy,
    output logic done
);

    localparam int STEP_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_BITS - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    adder_op_t         adder_op;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        clr_ax   = 1'b0;
        ld_b     = 1'b0;
        ld_ax    = 1'b0;
        shift    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        adder_op = OP_ADD;

        unique case (state_q)
            IDLE: begin
                // Gated by Reset_n so a held load switch cannot leak through during reset.
                if (ClearA_LoadB) begin
                    clr_ax = Reset_n;
                    ld_b   = Reset_n;
                end else if (Run) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                clr_ax  = 1'b1;
                busy    = 1'b1;
                step_d  = '0;
                state_d = ADD;
            end
            ADD: begin
                busy    = 1'b1;
                ld_ax   = M;
                state_d = SHIFT;
                if (step_q == LAST_STEP) begin
                    adder_op = OP_SUB;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = HOLD;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = ADD;
                end
            end
            HOLD: begin
                done = 1'b1;
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase

        sub_sel = adder_op;
    end

endmodule
